// File: rtl/spi_ss_sequencer_if.sv
// Slave-select sequencer bus: the PIO request and SPI busy inputs, plus the
// timed select, ready, busy and watchdog outputs.
interface spi_ss_sequencer_if;
   logic ss_req_n;
   logic spi_busy;
   logic ss_n;
   logic ss_ready;
   logic seq_busy;
   logic timeout_err;

   // Sequencer side
   modport slave (
      input  ss_req_n,
      input  spi_busy,
      output ss_n,
      output ss_ready,
      output seq_busy,
      output timeout_err
   );

   // Host / SPI core side
   modport master (
      output ss_req_n,
      output spi_busy,
      input  ss_n,
      input  ss_ready,
      input  seq_busy,
      input  timeout_err
   );
endinterface

// File: rtl/spi_ss_sequencer.sv
// Slave-select timing sequencer: stretches a manual SS request into a select
// with lead, trail and minimum-gap timing around the SPI core's transfers.
// Optional idle-select watchdog is enabled by defining SPI_SS_SEQ_TIMEOUT_EN.
module spi_ss_sequencer #(
   parameter int unsigned LEAD_CYCLES    = 2,
   parameter int unsigned TRAIL_CYCLES   = 3,
   parameter int unsigned GAP_CYCLES     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input logic               clk,
   input logic               reset,
   spi_ss_sequencer_if.slave bus
);

   typedef enum logic [2:0] {StIdle, StLead, StActive, StTrail, StGap} state_e;

   // Terminal counts; the counter clears on every state change so it never wraps
   localparam logic [7:0] LeadLast  = 8'(LEAD_CYCLES - 1);
   localparam logic [7:0] TrailLast = 8'(TRAIL_CYCLES - 1);
   localparam logic [7:0] GapLast   = 8'(GAP_CYCLES - 1);

   state_e     state_q;
   logic [7:0] cnt_q;
   logic       ss_n_q;
   logic       ss_ready_q;
   logic       seq_busy_q;

`ifdef SPI_SS_SEQ_TIMEOUT_EN
   localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] wd_q;
   logic        timeout_err_q;
`endif

   // Sequencer FSM with registered select, ready and busy outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         ss_n_q        <= 1'b1;
         ss_ready_q    <= 1'b0;
         seq_busy_q    <= 1'b0;
`ifdef SPI_SS_SEQ_TIMEOUT_EN
         wd_q          <= '0;
         timeout_err_q <= 1'b0;
`endif
      end else begin
         ss_ready_q <= 1'b0;
         case (state_q)
            StIdle: begin
`ifdef SPI_SS_SEQ_TIMEOUT_EN
               // A released request acknowledges a watchdog trip
               if (bus.ss_req_n) timeout_err_q <= 1'b0;
               if (!bus.ss_req_n && !timeout_err_q) begin
`else
               if (!bus.ss_req_n) begin
`endif
                  state_q    <= StLead;
                  cnt_q      <= '0;
                  ss_n_q     <= 1'b0;
                  seq_busy_q <= 1'b1;
               end
            end
            StLead: begin
               if (bus.ss_req_n) begin
                  // Abort still honours the trail hold
                  state_q <= StTrail;
                  cnt_q   <= '0;
               end else if (cnt_q == LeadLast) begin
                  state_q    <= StActive;
                  cnt_q      <= '0;
                  ss_ready_q <= 1'b1;
`ifdef SPI_SS_SEQ_TIMEOUT_EN
                  wd_q       <= '0;
`endif
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            StActive: begin
`ifdef SPI_SS_SEQ_TIMEOUT_EN
               if (bus.spi_busy) wd_q <= '0;
`endif
               if (bus.ss_req_n) begin
                  // Never cut an in-flight transfer
                  if (!bus.spi_busy) begin
                     state_q <= StTrail;
                     cnt_q   <= '0;
                  end
               end else begin
`ifdef SPI_SS_SEQ_TIMEOUT_EN
                  if (bus.spi_busy) begin
                     ss_ready_q <= 1'b1;
                  end else if (wd_q == TimeoutLast) begin
                     state_q       <= StTrail;
                     cnt_q         <= '0;
                     timeout_err_q <= 1'b1;
                  end else begin
                     wd_q       <= wd_q + 16'd1;
                     ss_ready_q <= 1'b1;
                  end
`else
                  ss_ready_q <= 1'b1;
`endif
               end
            end
            StTrail: begin
               if (cnt_q == TrailLast) begin
                  state_q <= StGap;
                  cnt_q   <= '0;
                  ss_n_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            StGap: begin
               if (cnt_q == GapLast) begin
                  state_q    <= StIdle;
                  cnt_q      <= '0;
                  seq_busy_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            default: begin
               state_q    <= StIdle;
               cnt_q      <= '0;
               ss_n_q     <= 1'b1;
               seq_busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ss_n     = ss_n_q;
   assign bus.ss_ready = ss_ready_q;
   assign bus.seq_busy = seq_busy_q;

`ifdef SPI_SS_SEQ_TIMEOUT_EN
   assign bus.timeout_err = timeout_err_q;
`else
   logic unused_timeout;
   assign unused_timeout  = ^TIMEOUT_CYCLES;
   assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: doc/spi_ss_sequencer.md
SPI_SS_SEQUENCER -- requirements
Module: spi_ss_sequencer

Interface
REQ-001 Clocking and reset SHALL be: one clock `clk`; reset `reset` is synchronous and active-high.
REQ-002 Parameter LEAD_CYCLES, default 2, SHALL set the number of cycles ss_n is low before ss_ready; legal range 1..255.
REQ-003 Parameter TRAIL_CYCLES, default 3, SHALL set the number of cycles ss_n stays low after the transfer ends; legal range 1..255.
REQ-004 Parameter GAP_CYCLES, default 4, SHALL set the minimum number of cycles ss_n is high between selects; legal range 1..255.
REQ-005 Parameter TIMEOUT_CYCLES, default 16, SHALL set the idle-select watchdog limit; legal range 1..65535; used only under the Configuration macro.
REQ-006 Port `clk`, input, 1 bit, SHALL be the system clock.
REQ-007 Port `reset`, input, 1 bit, SHALL be the synchronous active-high reset.
REQ-008 Port `ss_req_n`, input, 1 bit, SHALL be the manual slave-select request from the SS PIO out_port (0 = request select).
REQ-009 Port `spi_busy`, input, 1 bit, SHALL be high while the SPI core is shifting.
REQ-010 Port `ss_n`, output, 1 bit, SHALL be the timed slave-select pin (active-low).
REQ-011 Port `ss_ready`, output, 1 bit, SHALL indicate that the SPI core may start a transfer.
REQ-012 Port `seq_busy`, output, 1 bit, SHALL be high whenever the state is not IDLE.
REQ-013 Port `timeout_err`, output, 1 bit, SHALL be the sticky watchdog flag.

Function
REQ-014 The block SHALL implement a 5-state machine: IDLE, LEAD, ACTIVE, TRAIL, GAP.
REQ-015 ss_n SHALL be a registered signal that is 0 in LEAD, ACTIVE and TRAIL, and 1 in IDLE and GAP.
REQ-016 In IDLE, when ss_req_n=0 is sampled (and timeout_err=0), the block SHALL go to LEAD with an 8-bit counter cleared; ss_n SHALL fall on that same edge.
REQ-017 In LEAD, the counter SHALL increment each cycle; when count reaches LEAD_CYCLES-1, the block SHALL go to ACTIVE; ss_ready SHALL therefore rise exactly LEAD_CYCLES cycles after ss_n falls.
REQ-018 In LEAD, sampling ss_req_n=1 SHALL abort to TRAIL (counter cleared), so the trail hold is still honoured.
REQ-019 ss_ready SHALL be 1 only in ACTIVE while ss_req_n=0, and SHALL be registered with the state.
REQ-020 In ACTIVE with ss_req_n=1 and spi_busy=0, the block SHALL go to TRAIL.
REQ-021 In ACTIVE with ss_req_n=1 and spi_busy=1, the block SHALL remain in ACTIVE with ss_ready=0 until spi_busy falls; an in-flight transfer is never cut.
REQ-022 In TRAIL, the block SHALL count TRAIL_CYCLES cycles, then go to GAP; ss_req_n returning to 0 during TRAIL SHALL be ignored.
REQ-023 In GAP, the block SHALL count GAP_CYCLES cycles, then always go to IDLE; a pending request SHALL be taken by IDLE on the next edge.
REQ-024 spi_busy=1 outside ACTIVE SHALL have no effect on state.
REQ-025 The counter SHALL never wrap, because all limits are at most 255 and the counter clears on every state change.

Reset
REQ-026 While reset=1 at a clk edge, the block SHALL force state IDLE, counters to 0, ss_n=1, ss_ready=0, seq_busy=0 and timeout_err=0.
REQ-027 Reset asserted mid-operation (any state) SHALL deassert ss_n on that edge without honouring TRAIL or GAP.
REQ-028 Reset SHALL take priority over all other inputs.

Configuration
REQ-029 With macro SPI_SS_SEQ_TIMEOUT_EN defined, a 16-bit watchdog SHALL count ACTIVE cycles with ss_req_n=0 and spi_busy=0, clearing whenever spi_busy=1.
REQ-030 With SPI_SS_SEQ_TIMEOUT_EN defined, when the watchdog reaches TIMEOUT_CYCLES the block SHALL go to TRAIL and set timeout_err=1.
REQ-031 With SPI_SS_SEQ_TIMEOUT_EN defined, timeout_err SHALL clear only when ss_req_n=1 is sampled in IDLE; while timeout_err=1, IDLE SHALL ignore requests.
REQ-032 With SPI_SS_SEQ_TIMEOUT_EN undefined, the watchdog SHALL not exist, timeout_err SHALL be tied to 0, and ACTIVE SHALL be held indefinitely.

Verification
REQ-033 The bench SHALL cover a basic select: defaults, ss_req_n falls at cycle 10, spi_busy high cycles 14-21, ss_req_n rises at cycle 18 -> ss_n low from edge 10; ss_ready 1 on cycles 12-17; TRAIL starts at the edge after spi_busy falls; ss_n high 3 cycles later, then stays high for at least 4 cycles.
REQ-034 The bench SHALL cover a lead abort: ss_req_n low for 1 cycle only -> LEAD then TRAIL; ss_n low for exactly 1+3 cycles; ss_ready never 1.
REQ-035 The bench SHALL cover a back-to-back request: ss_req_n re-asserted during TRAIL -> ss_n high for exactly 4 GAP cycles plus 1 IDLE cycle before falling again.
REQ-036 The bench SHALL cover reset mid-ACTIVE: reset pulsed for 1 cycle in ACTIVE -> ss_n=1, ss_ready=0 and seq_busy=0 on that edge.
REQ-037 The bench SHALL cover the watchdog with SPI_SS_SEQ_TIMEOUT_EN defined: ss_req_n held low, spi_busy=0 -> after 16 ACTIVE cycles, TRAIL, and timeout_err=1 sticky; no reselect until ss_req_n=1 is seen in IDLE, which clears timeout_err.
REQ-038 The bench SHALL cover the watchdog disabled, with SPI_SS_SEQ_TIMEOUT_EN undefined: same stimulus for 1000 cycles -> stays in ACTIVE; timeout_err=0.
